// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter (fetch IF, memory-access MA) for one single-cycle-latency memory port.
// Define MEMORY_PORT_ARBITER_STARVE_GUARD_EN to compile in the IF anti-starvation guard.
module memory_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_grant,
    output logic [15:0] if_rdata,
    output logic        if_rvalid,
    input  logic        if_flush,
    input  logic        ma_req,
    input  logic        ma_we,
    input  logic [15:0] ma_addr,
    input  logic [15:0] ma_wdata,
    output logic        ma_grant,
    output logic [15:0] ma_rdata,
    output logic        ma_rvalid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_ma
);

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_IF_RD = 2'd1,
        TAG_MA_RD = 2'd2,
        TAG_MA_WR = 2'd3
    } tag_t;

    logic        force_if_s;
    logic        if_grant_s;
    logic        ma_grant_s;
    tag_t        tag_c1_next_s;
    tag_t        tag_c1_r;
    logic [15:0] mem_addr_r;
    logic [15:0] mem_wdata_r;
    logic        mem_we_r;
    logic        if_rvalid_r;
    logic        ma_rvalid_r;

`ifdef MEMORY_PORT_ARBITER_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_r;

    // Count consecutive cycles IF waits; saturate so IF keeps priority until it transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (if_req && !if_grant_s) begin
            if (starve_cnt_r != CNT_MAX) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign force_if_s = (starve_cnt_r == CNT_MAX);
`else
    // Strict MA priority: the limit never takes effect in this build.
    assign force_if_s = (STARVE_LIMIT < 0);
`endif

    // Grant selection: MA (older instruction) first unless IF has been starved.
    always_comb begin
        if_grant_s = 1'b0;
        ma_grant_s = 1'b0;
        if (reset) begin
            if_grant_s = 1'b0;
            ma_grant_s = 1'b0;
        end else if (if_req && (force_if_s || !ma_req)) begin
            if_grant_s = 1'b1;
        end else if (ma_req) begin
            ma_grant_s = 1'b1;
        end else begin
            if_grant_s = 1'b0;
            ma_grant_s = 1'b0;
        end
    end

    // Owner tag for the access entering C1; a flush on the transfer edge drops an IF read.
    always_comb begin
        tag_c1_next_s = TAG_NONE;
        if (ma_grant_s) begin
            tag_c1_next_s = ma_we ? TAG_MA_WR : TAG_MA_RD;
        end else if (if_grant_s && !if_flush) begin
            tag_c1_next_s = TAG_IF_RD;
        end else begin
            tag_c1_next_s = TAG_NONE;
        end
    end

    // C1 stage: launch the accepted access on the memory port, hold address/data when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_c1_r    <= TAG_NONE;
            mem_addr_r  <= 16'h0000;
            mem_wdata_r <= 16'h0000;
            mem_we_r    <= 1'b0;
        end else begin
            tag_c1_r <= tag_c1_next_s;
            if (ma_grant_s) begin
                mem_addr_r  <= ma_addr;
                mem_wdata_r <= ma_wdata;
                mem_we_r    <= ma_we;
            end else if (if_grant_s) begin
                mem_addr_r <= if_addr;
                mem_we_r   <= 1'b0;
            end else begin
                mem_we_r <= 1'b0;
            end
        end
    end

    // C2 stage: the owner tag becomes the response valid when read data is returned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rvalid_r <= 1'b0;
            ma_rvalid_r <= 1'b0;
        end else begin
            if_rvalid_r <= (tag_c1_r == TAG_IF_RD) && !if_flush;
            ma_rvalid_r <= (tag_c1_r == TAG_MA_RD);
        end
    end

    assign if_grant  = if_grant_s;
    assign ma_grant  = ma_grant_s;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_we    = mem_we_r;
    assign if_rvalid = if_rvalid_r;
    assign ma_rvalid = ma_rvalid_r;
    assign if_rdata  = mem_rdata;
    assign ma_rdata  = mem_rdata;
    assign stall_if  = if_req & ~if_grant_s;
    assign stall_ma  = ma_req & ~ma_grant_s;

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive denied IF-request cycles before IF is forced to win.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports if_req (in, 1), if_addr (in, 16), if_grant (out, 1), if_rdata (out, 16), if_rvalid (out, 1), if_flush (in, 1): the fetch read channel plus a branch-redirect kill.
REQ-005 SHALL have ports ma_req (in, 1), ma_we (in, 1), ma_addr (in, 16), ma_wdata (in, 16), ma_grant (out, 1), ma_rdata (out, 16), ma_rvalid (out, 1): the memory-access load/store channel.
REQ-006 SHALL have ports mem_addr (out, 16), mem_wdata (out, 16), mem_we (out, 1), mem_rdata (in, 16): the single shared memory port.
REQ-007 SHALL have ports stall_if (out, 1) = if_req & ~if_grant, and stall_ma (out, 1) = ma_req & ~ma_grant.

Function
REQ-008 Transfer SHALL occur on a rising edge where req & grant are both high; requesters hold req/addr/we/wdata stable until transfer.
REQ-009 Grants SHALL be combinational from req inputs and registered state; at most one grant is high per cycle; no grant without its req.
REQ-010 Default priority: MA wins when both request (older instruction first).
REQ-011 Accepted request fields SHALL be registered onto mem_addr/mem_wdata/mem_we in the cycle after transfer (C1); mem_we SHALL be high in C1 only for an MA write, otherwise 0.
REQ-012 mem_addr/mem_wdata SHALL hold their last value when no transfer occurs.
REQ-013 Memory returns mem_rdata one cycle after mem_addr (C2); an owner tag (NONE, IF_RD, MA_RD, MA_WR) SHALL pipeline C1->C2.
REQ-014 In C2, owner IF_RD SHALL assert if_rvalid for one cycle; owner MA_RD SHALL assert ma_rvalid for one cycle; MA_WR and NONE assert neither.
REQ-015 if_rdata and ma_rdata SHALL both pass mem_rdata through; only the rvalid qualifies them.
REQ-016 Back-to-back transfers SHALL be accepted every cycle; throughput is one access per cycle, latency transfer->rvalid is 2 cycles.
REQ-017 if_flush high on a rising edge SHALL convert any IF_RD tag in C1 or C2 to NONE, suppressing the corresponding if_rvalid; MA tags are unaffected.
REQ-018 if_flush simultaneous with an IF transfer SHALL also drop that transfer's tag (no if_rvalid), while the memory read still issues.
REQ-019 if_flush SHALL not alter grants or the starvation counter.

Reset
REQ-020 While reset is high: if_grant, ma_grant, if_rvalid, ma_rvalid, mem_we = 0; mem_addr, mem_wdata = 0; owner tags = NONE; starvation counter = 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight accesses; no rvalid for them after release.
REQ-022 First transfer SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-023 Macro MEMORY_PORT_ARBITER_STARVE_GUARD_EN compiles in the IF anti-starvation guard.
REQ-024 With the macro: a counter increments each cycle if_req is high and IF does not transfer, clears on IF transfer or if_req low, saturates at STARVE_LIMIT; when it equals STARVE_LIMIT, IF wins over MA.
REQ-025 Without the macro: strict MA priority, no counter, STARVE_LIMIT unused.

Verification
REQ-026 IF-only read: if_req=1, if_addr=0x0010 -> if_grant same cycle; mem_addr=0x0010 next cycle; if_rvalid with mem_rdata two cycles after transfer.
REQ-027 Simultaneous requests: ma_req (we=1, addr=0x0200, wdata=0xBEEF) and if_req -> ma_grant, mem_we=1 one cycle, stall_if=1; IF granted the following cycle.
REQ-028 Back-to-back MA read 0x0100 then IF read 0x0004 -> ma_rvalid and if_rvalid in consecutive cycles, each with correct rdata.
REQ-029 Guard enabled, STARVE_LIMIT=4, ma_req held high with if_req high -> IF wins on the 5th cycle; guard disabled -> IF never granted.
REQ-030 IF transfer then if_flush one cycle later -> no if_rvalid; reset asserted in C1 of an MA read -> no ma_rvalid, all outputs 0.
